// File: rtl/inst_fetch_buffer_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_buffer_pkg
//   Shared constants for the instruction fetch buffer: machine word width,
//   instruction width, default queue depth and the sequential PC step.
//   Imported by ifb_fifo and inst_fetch_buffer.
// -----------------------------------------------------------------------------
package inst_fetch_buffer_pkg;

  // Machine word (address / PC) width.
  localparam int WORD      = 64;
  // Instruction width.
  localparam int INST_SIZE = 32;
  // Default number of queued instructions.
  localparam int IFB_DEPTH = 4;
  // Byte distance between consecutive sequential fetches.
  localparam int PC_STEP   = 4;

endpackage : inst_fetch_buffer_pkg

// File: rtl/ifb_fifo.sv
// -----------------------------------------------------------------------------
// ifb_fifo
//   Synchronous first-word-fall-through FIFO with flush. The head entry is
//   visible on o_rdata whenever o_valid is high; a pop advances it.
//   Flush empties the queue and wins over push and pop in the same cycle.
//
// Ports
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset (control state only)
//   i_flush  in   empty the FIFO on the next edge
//   i_push   in   write i_wdata (caller guarantees the FIFO is not full)
//   i_wdata  in   W-bit entry to write
//   i_pop    in   consume the head entry (ignored when empty)
//   o_rdata  out  head entry
//   o_valid  out  FIFO holds at least one entry
//   o_count  out  occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module ifb_fifo
  import inst_fetch_buffer_pkg::*;
#(
  parameter int DEPTH = IFB_DEPTH,
  parameter int W     = WORD + INST_SIZE
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_flush,
  input  logic                         i_push,
  input  logic [W-1:0]                 i_wdata,
  input  logic                         i_pop,
  output logic [W-1:0]                 o_rdata,
  output logic                         o_valid,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [CW-1:0] r_count;

  logic          w_push;
  logic          w_pop;

  assign w_push = i_push & ~i_flush;
  assign w_pop  = i_pop & (r_count != '0) & ~i_flush;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop)  r_rd <= r_rd + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd];
  assign o_valid = (r_count != '0);
  assign o_count = r_count;

endmodule : ifb_fifo

// File: rtl/inst_fetch_buffer.sv
// -----------------------------------------------------------------------------
// inst_fetch_buffer
//   Decoupled fetch stage between a variable-latency instruction memory
//   (one outstanding req/ack transaction) and the decode stage (valid/ready).
//   Sequential fetch addresses come from the fetch PC (fpc); returned words are
//   queued with their PC in ifb_fifo. A redirect flushes the queue and restarts
//   fetching at redirect_pc (word aligned). A request already on the memory
//   port when a redirect arrives is held stable until acked and then dropped.
//
//   A request is only issued while the queue has a free slot, so a push never
//   targets a full FIFO.
//
//   Build option: define IFB_BYPASS_EN to forward an ack straight to the
//   decode side when the queue is empty (zero-latency). Without it, no
//   combinational path exists from imem_* to inst_*.
//
// Ports
//   clk          in   clock
//   rst_n        in   asynchronous active-low reset
//   redirect     in   flush and restart fetch at redirect_pc
//   redirect_pc  in   new fetch PC (low two bits ignored)
//   imem_req     out  instruction memory request
//   imem_addr    out  request address
//   imem_ack     in   imem_inst valid; completes the request
//   imem_inst    in   returned instruction
//   inst_valid   out  head entry valid
//   inst         out  head instruction (holds while inst_valid is low)
//   inst_pc      out  PC of head instruction (holds while inst_valid is low)
//   inst_ready   in   decode consumes the head entry
//   count        out  FIFO occupancy
// -----------------------------------------------------------------------------
module inst_fetch_buffer
  import inst_fetch_buffer_pkg::*;
#(
  parameter int            DEPTH    = IFB_DEPTH,
  parameter int            AW       = WORD,
  parameter int            IW       = INST_SIZE,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       redirect,
  input  logic [AW-1:0]              redirect_pc,
  output logic                       imem_req,
  output logic [AW-1:0]              imem_addr,
  input  logic                       imem_ack,
  input  logic [IW-1:0]              imem_inst,
  output logic                       inst_valid,
  output logic [IW-1:0]              inst,
  output logic [AW-1:0]              inst_pc,
  input  logic                       inst_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int            CW      = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [AW-1:0] PC_INC  = AW'(PC_STEP);
  localparam logic [AW-1:0] PC_MASK = ~AW'(3);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_fpc;
  logic [AW-1:0] w_fpc_nxt;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] w_addr_nxt;
  logic [IW-1:0] r_hold_inst;
  logic [AW-1:0] r_hold_pc;

  logic [AW-1:0] w_redirect_pc;
  logic          w_accept;
  logic          w_bypass;
  logic          w_push;
  logic          w_pop;

  logic              w_fifo_valid;
  logic [AW+IW-1:0]  w_fifo_rdata;
  logic [IW-1:0]     w_fifo_inst;
  logic [AW-1:0]     w_fifo_pc;
  logic [CW-1:0]     w_count;

  assign w_redirect_pc = redirect_pc & PC_MASK;

  // An ack that actually delivers an instruction: live request, no redirect.
  assign w_accept = (r_state == S_REQ) & imem_ack & ~redirect;

`ifdef IFB_BYPASS_EN
  // Empty queue: hand the acked word straight to decode this cycle.
  assign w_bypass = w_accept & (w_count == '0);
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed word consumed in the same cycle never enters the queue.
  assign w_push = w_accept & ~(w_bypass & inst_ready);
  assign w_pop  = w_fifo_valid & inst_ready;

  // --------------------------------------------------------------------------
  // Fetch FSM: next state, fetch PC and request address
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_fpc_nxt   = r_fpc;
    w_addr_nxt  = r_addr;

    case (r_state)
      S_IDLE: begin
        // The push of the previous transaction is already reflected in
        // w_count here, so occupancy alone guarantees a free slot.
        if (!redirect && (w_count < DEPTH_C)) begin
          w_state_nxt = S_REQ;
          w_addr_nxt  = r_fpc;
        end
      end
      S_REQ: begin
        if (imem_ack) begin
          w_state_nxt = S_IDLE;
          if (!redirect) w_fpc_nxt = r_fpc + PC_INC;
        end else if (redirect) begin
          // Memory needs a stable request; wait out the stale ack.
          w_state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_ack) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // A redirect in any state retargets the fetch PC.
    if (redirect) w_fpc_nxt = w_redirect_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_fpc   <= RESET_PC;
      r_addr  <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_fpc   <= w_fpc_nxt;
      r_addr  <= w_addr_nxt;
    end
  end

  assign imem_req  = (r_state == S_REQ) | (r_state == S_DROP);
  assign imem_addr = r_addr;

  // --------------------------------------------------------------------------
  // Instruction queue
  // --------------------------------------------------------------------------
  ifb_fifo #(
    .DEPTH (DEPTH),
    .W     (AW + IW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (redirect),
    .i_push  (w_push),
    .i_wdata ({imem_inst, r_fpc}),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_valid (w_fifo_valid),
    .o_count (w_count)
  );

  assign w_fifo_inst = w_fifo_rdata[AW+IW-1:AW];
  assign w_fifo_pc   = w_fifo_rdata[AW-1:0];
  assign count       = w_count;

  // --------------------------------------------------------------------------
  // Decode-side outputs; the last presented entry is held while idle
  // --------------------------------------------------------------------------
  always_comb begin
    inst_valid = w_fifo_valid | w_bypass;
    inst       = r_hold_inst;
    inst_pc    = r_hold_pc;
    if (w_fifo_valid) begin
      inst    = w_fifo_inst;
      inst_pc = w_fifo_pc;
    end else if (w_bypass) begin
      inst    = imem_inst;
      inst_pc = r_fpc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_inst <= '0;
      r_hold_pc   <= '0;
    end else if (inst_valid) begin
      r_hold_inst <= inst;
      r_hold_pc   <= inst_pc;
    end
  end

endmodule : inst_fetch_buffer

// File: tb/tb_inst_fetch_buffer.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_buffer
//   Directed bench for inst_fetch_buffer (DEPTH=4, RESET_PC=0, AW=64, IW=32).
//   Inputs change on the falling edge; outputs are sampled on the falling
//   edge, or 1 time unit after an input change where a same-cycle response
//   is expected. Memory contents are a fixed function of the address.
// -----------------------------------------------------------------------------
module tb_inst_fetch_buffer;

  localparam int AW    = 64;
  localparam int IW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk;
  logic          rst_n;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [IW-1:0] imem_inst;
  logic          inst_valid;
  logic [IW-1:0] inst;
  logic [AW-1:0] inst_pc;
  logic          inst_ready;
  logic [CW-1:0] count;

  int n_cmp = 0;
  int n_bad = 0;

  inst_fetch_buffer #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .IW       (IW),
    .RESET_PC ('0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_inst   (imem_inst),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return 32'hC0DE_0000 ^ a[31:0];
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  // Reset, release on a falling edge; the first request shows one cycle later.
  task automatic do_reset();
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_ack    = 1'b0;
    imem_inst   = '0;
    inst_ready  = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Ack the current request immediately with the addressed word.
  task automatic ack_now(input string tag, input logic [63:0] exp_addr);
    chk({tag, "_req"}, 64'(imem_req), 64'd1);
    chk({tag, "_addr"}, imem_addr, exp_addr);
    imem_ack  = 1'b1;
    imem_inst = mem_word(exp_addr);
  endtask

  initial begin
    int npop;
    int nreq;

    // ---------------- reset values ----------------
    do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_req",   64'(imem_req),   64'd0);
    chk("rst_addr",  imem_addr,       64'h0);
    chk("rst_valid", 64'(inst_valid), 64'd0);
    chk("rst_inst",  64'(inst),       64'd0);
    chk("rst_pc",    inst_pc,         64'h0);
    chk("rst_cnt",   64'(count),      64'd0);

    // ---------------- T1: zero-latency memory, ready=1 ----------------
    do_reset();
    inst_ready = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      ack_now("t1", 64'(4*k));
      #1;
`ifdef IFB_BYPASS_EN
      chk("t1_byp_valid", 64'(inst_valid), 64'd1);
      chk("t1_byp_pc",    inst_pc,         64'(4*k));
      chk("t1_byp_inst",  64'(inst),       64'(mem_word(64'(4*k))));
      step();
      imem_ack = 1'b0;
      #1;
      chk("t1_byp_cnt", 64'(count), 64'd0);
`else
      chk("t1_lat_valid", 64'(inst_valid), 64'd0);
      step();
      imem_ack = 1'b0;
      #1;
      chk("t1_valid", 64'(inst_valid), 64'd1);
      chk("t1_pc",    inst_pc,         64'(4*k));
      chk("t1_inst",  64'(inst),       64'(mem_word(64'(4*k))));
`endif
      chk("t1_req_lo", 64'(imem_req), 64'd0);
      step();
    end

    // ---------------- T2: fill with ready=0, then drain ----------------
    do_reset();
    step();
    for (int k = 0; k < 4; k++) begin
      ack_now("t2_fill", 64'(4*k));
      step();
      imem_ack = 1'b0;
      #1;
      chk("t2_cnt",  64'(count), 64'(k+1));
      chk("t2_head", inst_pc,    64'h0);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      chk("t2_full_req", 64'(imem_req), 64'd0);
      chk("t2_full_cnt", 64'(count),    64'd4);
      step();
    end
    inst_ready = 1'b1;
    npop = 0;
    nreq = 4;
    for (int c = 0; c < 40 && npop < 6; c++) begin
      if (imem_req) begin
        chk("t2_raddr", imem_addr, 64'(4*nreq));
        imem_ack  = 1'b1;
        imem_inst = mem_word(imem_addr);
        nreq++;
      end else begin
        imem_ack = 1'b0;
      end
      #1;
      if (inst_valid) begin
        chk("t2_pop_pc",   inst_pc,   64'(4*npop));
        chk("t2_pop_inst", 64'(inst), 64'(mem_word(64'(4*npop))));
        npop++;
      end
      step();
    end
    imem_ack = 1'b0;
    chk("t2_npop", 64'(npop), 64'd6);

    // ---------------- T3: ack delayed 5 cycles ----------------
    do_reset();
    step();
    chk("t3_req0",  64'(imem_req), 64'd1);
    chk("t3_addr0", imem_addr,     64'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_req_hold",  64'(imem_req),   64'd1);
      chk("t3_addr_hold", imem_addr,       64'h0);
      chk("t3_valid_lo",  64'(inst_valid), 64'd0);
    end
    ack_now("t3", 64'h0);
    step();
    imem_ack = 1'b0;
    #1;
    chk("t3_valid", 64'(inst_valid), 64'd1);
    chk("t3_pc",    inst_pc,         64'h0);
    chk("t3_inst",  64'(inst),       64'(mem_word(64'h0)));

    // ---------------- T4: redirect during REQ, no ack ----------------
    do_reset();
    inst_ready = 1'b1;
    step();
    chk("t4_addr0", imem_addr, 64'h0);
    redirect    = 1'b1;
    redirect_pc = 64'h100;
    step();
    redirect = 1'b0;
    chk("t4_drop_req",  64'(imem_req), 64'd1);
    chk("t4_drop_addr", imem_addr,     64'h0);
    imem_ack  = 1'b1;
    imem_inst = 32'hDEAD_BEEF;
    #1;
    chk("t4_drop_valid", 64'(inst_valid), 64'd0);
    step();
    imem_ack = 1'b0;
    #1;
    chk("t4_idle_req", 64'(imem_req),   64'd0);
    chk("t4_idle_vld", 64'(inst_valid), 64'd0);
    chk("t4_idle_cnt", 64'(count),      64'd0);
    step();
    ack_now("t4_new", 64'h100);
    #1;
`ifdef IFB_BYPASS_EN
    chk("t4_byp_valid", 64'(inst_valid), 64'd1);
    chk("t4_byp_pc",    inst_pc,         64'h100);
    step();
    imem_ack = 1'b0;
`else
    step();
    imem_ack = 1'b0;
    #1;
    chk("t4_valid", 64'(inst_valid), 64'd1);
    chk("t4_pc",    inst_pc,         64'h100);
    chk("t4_inst",  64'(inst),       64'(mem_word(64'h100)));
`endif

    // ---------------- T5: redirect + ack + pop with count=2 ----------------
    do_reset();
    step();
    for (int k = 0; k < 2; k++) begin
      ack_now("t5_fill", 64'(4*k));
      step();
      imem_ack = 1'b0;
      step();
    end
    chk("t5_cnt2",  64'(count), 64'd2);
    chk("t5_addr8", imem_addr,  64'h8);
    ack_now("t5_clash", 64'h8);
    inst_ready  = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 64'h203;
    step();
    imem_ack   = 1'b0;
    redirect   = 1'b0;
    inst_ready = 1'b0;
    #1;
    chk("t5_cnt0",    64'(count),      64'd0);
    chk("t5_valid",   64'(inst_valid), 64'd0);
    chk("t5_req_lo",  64'(imem_req),   64'd0);
    chk("t5_pc_hold", inst_pc,         64'h0);
    step();
    chk("t5_req",  64'(imem_req), 64'd1);
    chk("t5_addr", imem_addr,     64'h200);

    // ---------------- T6: reset mid-REQ with 3 queued ----------------
    do_reset();
    step();
    for (int k = 0; k < 3; k++) begin
      ack_now("t6_fill", 64'(4*k));
      step();
      imem_ack = 1'b0;
      step();
    end
    chk("t6_cnt3", 64'(count),    64'd3);
    chk("t6_req",  64'(imem_req), 64'd1);
    chk("t6_addr", imem_addr,     64'hC);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_req",   64'(imem_req),   64'd0);
    chk("t6_rst_valid", 64'(inst_valid), 64'd0);
    chk("t6_rst_cnt",   64'(count),      64'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("t6_restart_req",  64'(imem_req), 64'd1);
    chk("t6_restart_addr", imem_addr,     64'h0);

`ifdef IFB_BYPASS_EN
    // ---------------- T7: bypass into empty FIFO ----------------
    do_reset();
    inst_ready = 1'b1;
    step();
    ack_now("t7", 64'h0);
    #1;
    chk("t7_valid", 64'(inst_valid), 64'd1);
    chk("t7_cnt",   64'(count),      64'd0);
    step();
    imem_ack = 1'b0;
    #1;
    chk("t7_cnt_after", 64'(count), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule : tb_inst_fetch_buffer
